reg_file_dec: RTL and testbench
===============================

REG_FILE_DEC -- requirements
Module: reg_file_dec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits (1..32).
REQ-002 The block SHALL have parameter AW, default 3, address width; DEPTH = 2**AW entries.
REQ-003 The block SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding.
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port clr  input  1  synchronous clear-all request.
REQ-007 The block SHALL have port we  input  1  write enable.
REQ-008 The block SHALL have port waddr  input  AW  write address.
REQ-009 The block SHALL have port wdata  input  WIDTH  write data.
REQ-010 The block SHALL have ports re0/re1  input  1  read enable, ports 0/1.
REQ-011 The block SHALL have ports raddr0/raddr1  input  AW  read addresses.
REQ-012 The block SHALL have ports rdata0/rdata1  output  WIDTH  registered read data.
REQ-013 The block SHALL have ports rvalid0/rvalid1  output  1  registered "entry was written" flag for the read data.
REQ-014 The block SHALL have port wsel  output  DEPTH  combinational one-hot write decode.
REQ-015 The block SHALL have port valid_cnt  output  AW+1  registered count of valid entries.
REQ-016 The block SHALL have port full  output  1  high when valid_cnt == DEPTH.

Function
REQ-017 Storage SHALL be DEPTH entries x WIDTH bits plus one valid bit per entry.
REQ-018 Write: at rising edge with we=1, clr=0 -> mem[waddr]<=wdata, valid[waddr]<=1.
REQ-019 clr=1 at rising edge SHALL zero all entries and valid bits; clr has priority over we.
REQ-020 wsel SHALL equal one-hot(waddr) when we=1 and clr=0, else all zeros; no clock latency.
REQ-021 Read latency SHALL be exactly 1 cycle: reN=1 at edge -> rdataN/rvalidN update at that edge from raddrN.
REQ-022 reN=0 at edge -> rdataN and rvalidN hold previous values.
REQ-023 Both read ports SHALL operate independently; same address on both ports returns identical data.
REQ-024 Read/write collision (we=1, clr=0, waddr==raddrN, reN=1), BYPASS=1 -> rdataN=wdata, rvalidN=1.
REQ-025 Same collision, BYPASS=0 -> rdataN/rvalidN reflect pre-write contents.
REQ-026 Read with clr=1 at same edge -> rdataN=0, rvalidN=0 regardless of BYPASS.
REQ-027 valid_cnt SHALL increment by 1 only when a write targets an entry whose valid bit is 0.
REQ-028 Rewriting an already-valid entry SHALL leave valid_cnt unchanged; valid_cnt never exceeds DEPTH.
REQ-029 clr SHALL set valid_cnt to 0 at the same edge, overriding any concurrent write.
REQ-030 full SHALL be derived combinationally from valid_cnt.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock edge, force all entries, valid bits, rdata0/1, rvalid0/1 and valid_cnt to 0.
REQ-032 While rst_n=0, writes and reads SHALL be ignored; wsel follows REQ-020.
REQ-033 First state update after rst_n rises SHALL occur on the next rising clk edge.
REQ-034 Reset asserted mid-operation SHALL discard all stored data; no partial state survives.

Verification (WIDTH=8, AW=3)
REQ-035 Reset, then re0=1 raddr0=5 -> rdata0=0x00, rvalid0=0, valid_cnt=0, full=0.
REQ-036 Write 0xA5 @3; next cycle read @3 -> rdata0=0xA5, rvalid0=1, valid_cnt=1; rewrite 0x5A @3 -> valid_cnt stays 1, read gives 0x5A.
REQ-037 Same-edge write 0x3C @6 and re1 @6 -> BYPASS=1: rdata1=0x3C, rvalid1=1; BYPASS=0: rdata1=0x00, rvalid1=0.
REQ-038 Write addresses 0..7 -> valid_cnt=8, full=1; then clr=1 with we=1 @2 -> valid_cnt=0, full=0, all reads 0x00/rvalid=0.
REQ-039 Hold re0=0 after reading 0xA5 while writing other data @3 -> rdata0 stays 0xA5.
REQ-040 we=1 waddr=2 -> wsel=8'b0000_0100; we=0 or clr=1 -> wsel=0; rst_n pulsed low between edges -> rdata0=0, valid_cnt=0 immediately.

Source files
------------

// File: rtl/reg_file_dec.sv
// Small register file: one write port with one-hot decode, two registered read ports
// with optional write-to-read forwarding, per-entry valid bits and a valid-entry count.
module reg_file_dec #(
   parameter int WIDTH  = 8,
   parameter int AW     = 3,
   parameter int BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  re0,
   input  logic                  re1,
   input  logic [AW-1:0]         raddr0,
   input  logic [AW-1:0]         raddr1,
   output logic [WIDTH-1:0]      rdata0,
   output logic [WIDTH-1:0]      rdata1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [(2**AW)-1:0]    wsel,
   output logic [AW:0]           valid_cnt,
   output logic                  full
);

   localparam int DEPTH = 2 ** AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic             do_write;
   logic             fwd0;
   logic             fwd1;

   assign do_write = we & ~clr;
   assign fwd0     = (BYPASS != 0) && do_write && (waddr == raddr0);
   assign fwd1     = (BYPASS != 0) && do_write && (waddr == raddr1);
   assign full     = (valid_cnt == (AW+1)'(DEPTH));

   // NOTE: give wsel a default before the conditional write so no latch is inferred.
   always_comb begin
      wsel = '0;
      if (do_write) wsel[waddr] = 1'b1;
   end

   // NOTE: the storage array sits under the async reset because a reset must wipe
   // every stored word immediately; this rules out a RAM macro, which is fine at this size.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         valid     <= '0;
         valid_cnt <= '0;
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         valid     <= '0;
         valid_cnt <= '0;
      end else if (we) begin
         mem[waddr]   <= wdata;
         valid[waddr] <= 1'b1;
         if (!valid[waddr]) valid_cnt <= valid_cnt + 1'b1;
      end
   end

   // Read ports see pre-write contents unless forwarding is enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata0  <= '0;
         rvalid0 <= 1'b0;
         rdata1  <= '0;
         rvalid1 <= 1'b0;
      end else begin
         if (re0) begin
            if (clr) begin
               rdata0  <= '0;
               rvalid0 <= 1'b0;
            end else if (fwd0) begin
               rdata0  <= wdata;
               rvalid0 <= 1'b1;
            end else begin
               rdata0  <= mem[raddr0];
               rvalid0 <= valid[raddr0];
            end
         end
         if (re1) begin
            if (clr) begin
               rdata1  <= '0;
               rvalid1 <= 1'b0;
            end else if (fwd1) begin
               rdata1  <= wdata;
               rvalid1 <= 1'b1;
            end else begin
               rdata1  <= mem[raddr1];
               rvalid1 <= valid[raddr1];
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_file_dec.sv
// Bench for reg_file_dec: forwarding and non-forwarding instances side by side,
// checked every cycle against an array model plus literal spot checks.
module tb_reg_file_dec;

   logic       clk = 1'b0;
   logic       rst_n, clr, we, re0, re1;
   logic [2:0] waddr, raddr0, raddr1;
   logic [7:0] wdata;

   logic [7:0] rdata0_b, rdata1_b, rdata0_n, rdata1_n;
   logic       rvalid0_b, rvalid1_b, rvalid0_n, rvalid1_n;
   logic [7:0] wsel_b, wsel_n;
   logic [3:0] cnt_b, cnt_n;
   logic       full_b, full_n;

   int vectors = 0;
   int errors  = 0;
   logic checking = 1'b0;

   // Model state; rd/rv indexed [bypass][port].
   logic [7:0] m_mem [8];
   logic       m_val [8];
   logic [7:0] m_rd  [2][2];
   logic       m_rv  [2][2];

   always #5 clk = ~clk;

   reg_file_dec #(.WIDTH(8), .AW(3), .BYPASS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .re0(re0), .re1(re1), .raddr0(raddr0), .raddr1(raddr1),
      .rdata0(rdata0_b), .rdata1(rdata1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
      .wsel(wsel_b), .valid_cnt(cnt_b), .full(full_b));

   reg_file_dec #(.WIDTH(8), .AW(3), .BYPASS(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .re0(re0), .re1(re1), .raddr0(raddr0), .raddr1(raddr1),
      .rdata0(rdata0_n), .rdata1(rdata1_n), .rvalid0(rvalid0_n), .rvalid1(rvalid1_n),
      .wsel(wsel_n), .valid_cnt(cnt_n), .full(full_n));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 8; i++) if (m_val[i]) n++;
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_mem[i] = 8'h00;
         m_val[i] = 1'b0;
      end
      for (int b = 0; b < 2; b++)
         for (int p = 0; p < 2; p++) begin
            m_rd[b][p] = 8'h00;
            m_rv[b][p] = 1'b0;
         end
   endtask

   // One clock edge of the specified behaviour: reads see old contents, then write/clear.
   task automatic model_step();
      logic       re_v [2];
      logic [2:0] ra_v [2];
      re_v[0] = re0; re_v[1] = re1;
      ra_v[0] = raddr0; ra_v[1] = raddr1;
      for (int p = 0; p < 2; p++) begin
         if (!re_v[p]) continue;
         for (int b = 0; b < 2; b++) begin
            if (clr) begin
               m_rd[b][p] = 8'h00; m_rv[b][p] = 1'b0;
            end else if (b == 1 && we && waddr == ra_v[p]) begin
               m_rd[b][p] = wdata; m_rv[b][p] = 1'b1;
            end else begin
               m_rd[b][p] = m_mem[ra_v[p]]; m_rv[b][p] = m_val[ra_v[p]];
            end
         end
      end
      if (clr) begin
         for (int i = 0; i < 8; i++) begin
            m_mem[i] = 8'h00; m_val[i] = 1'b0;
         end
      end else if (we) begin
         m_mem[waddr] = wdata;
         m_val[waddr] = 1'b1;
      end
   endtask

   task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                        input logic r0, input logic [2:0] a0,
                        input logic r1, input logic [2:0] a1, input logic c);
      we = w; waddr = wa; wdata = wd;
      re0 = r0; raddr0 = a0; re1 = r1; raddr1 = a1; clr = c;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #2;
   endtask

   // Compare process: outputs registered at the last rising edge, checked on the falling edge.
   always @(negedge clk) begin
      if (checking) begin
         logic [7:0] exp_wsel;
         int         cnt;
         exp_wsel = (we && !clr) ? (8'h01 << waddr) : 8'h00;
         cnt      = model_count();
         check("rdata0_byp",  {24'h0, rdata0_b},  {24'h0, m_rd[1][0]});
         check("rvalid0_byp", {31'h0, rvalid0_b}, {31'h0, m_rv[1][0]});
         check("rdata1_byp",  {24'h0, rdata1_b},  {24'h0, m_rd[1][1]});
         check("rvalid1_byp", {31'h0, rvalid1_b}, {31'h0, m_rv[1][1]});
         check("rdata0_nobyp",  {24'h0, rdata0_n},  {24'h0, m_rd[0][0]});
         check("rvalid0_nobyp", {31'h0, rvalid0_n}, {31'h0, m_rv[0][0]});
         check("rdata1_nobyp",  {24'h0, rdata1_n},  {24'h0, m_rd[0][1]});
         check("rvalid1_nobyp", {31'h0, rvalid1_n}, {31'h0, m_rv[0][1]});
         check("valid_cnt_byp",   {28'h0, cnt_b}, cnt);
         check("valid_cnt_nobyp", {28'h0, cnt_n}, cnt);
         check("full_byp",   {31'h0, full_b}, {31'h0, cnt == 8});
         check("full_nobyp", {31'h0, full_n}, {31'h0, cnt == 8});
         check("wsel_byp",   {24'h0, wsel_b}, {24'h0, exp_wsel});
         check("wsel_nobyp", {24'h0, wsel_n}, {24'h0, exp_wsel});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 8'h00, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      checking = 1'b1;
      check("reset_cnt",  {28'h0, cnt_b}, 32'd0);
      check("reset_full", {31'h0, full_b}, 32'd0);

      // Read of an unwritten entry after reset.
      drive(0, 0, 8'h00, 1, 3'd5, 0, 0, 0); tick();
      check("rd5_data",  {24'h0, rdata0_b}, 32'h00);
      check("rd5_valid", {31'h0, rvalid0_b}, 32'd0);

      // Write then read back; rewrite with read port idle must hold the old data.
      drive(1, 3'd3, 8'hA5, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 8'h00, 1, 3'd3, 0, 0, 0); tick();
      check("rd3_a5",    {24'h0, rdata0_b}, 32'hA5);
      check("rd3_valid", {31'h0, rvalid0_b}, 32'd1);
      check("cnt_one",   {28'h0, cnt_b}, 32'd1);
      drive(1, 3'd3, 8'h5A, 0, 0, 0, 0, 0); tick();
      check("hold_a5",   {24'h0, rdata0_b}, 32'hA5);
      check("cnt_rewr",  {28'h0, cnt_b}, 32'd1);
      drive(0, 0, 8'h00, 1, 3'd3, 1, 3'd3, 0); tick();
      check("rd3_5a",    {24'h0, rdata0_b}, 32'h5A);
      check("same_addr", {24'h0, rdata1_b}, 32'h5A);

      // Same-edge write/read collision on port 1.
      drive(1, 3'd6, 8'h3C, 0, 0, 1, 3'd6, 0);
      #1 check("wsel_6", {24'h0, wsel_b}, 32'h40);
      tick();
      check("coll_byp_data",    {24'h0, rdata1_b}, 32'h3C);
      check("coll_byp_valid",   {31'h0, rvalid1_b}, 32'd1);
      check("coll_nobyp_data",  {24'h0, rdata1_n}, 32'h00);
      check("coll_nobyp_valid", {31'h0, rvalid1_n}, 32'd0);

      // Fill every entry, reading back through port 0 with the write in flight.
      for (int i = 0; i < 8; i++) begin
         drive(1, 3'(i), 8'(8'h10 + i), 1, 3'(i), 1, 3'(7 - i), 0);
         if (i == 2) #1 check("wsel_2", {24'h0, wsel_b}, 32'h04);
         tick();
      end
      check("cnt_full",  {28'h0, cnt_b}, 32'd8);
      check("full_set",  {31'h0, full_b}, 32'd1);

      // Clear beats a concurrent write; wsel is suppressed.
      drive(1, 3'd2, 8'hEE, 1, 3'd2, 1, 3'd7, 1);
      #1 check("wsel_clr", {24'h0, wsel_b}, 32'h00);
      tick();
      check("clr_cnt",   {28'h0, cnt_b}, 32'd0);
      check("clr_full",  {31'h0, full_b}, 32'd0);
      check("clr_rd0",   {24'h0, rdata0_b}, 32'h00);
      check("clr_rv1",   {31'h0, rvalid1_b}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 3'(i), 8'hFF, 1, 3'(i), 1, 3'(i), 0);
         #1 check("wsel_we0", {24'h0, wsel_b}, 32'h00);
         tick();
      end

      // A few mixed writes, then an asynchronous reset between edges.
      drive(1, 3'd1, 8'h77, 1, 3'd1, 1, 3'd0, 0); tick();
      drive(1, 3'd0, 8'h99, 1, 3'd1, 1, 3'd0, 0); tick();
      drive(0, 3'd0, 8'h00, 1, 3'd1, 0, 3'd0, 0); tick();
      check("pre_rst_rd", {24'h0, rdata0_b}, 32'h77);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rd0", {24'h0, rdata0_b}, 32'h00);
      check("async_cnt", {28'h0, cnt_b}, 32'd0);
      check("async_rv1", {31'h0, rvalid1_b}, 32'd0);
      drive(1, 3'd4, 8'h44, 1, 3'd1, 0, 0, 0); tick();
      rst_n = 1'b1;
      drive(0, 3'd0, 8'h00, 1, 3'd1, 1, 3'd4, 0); tick();
      check("post_rst_rd1", {24'h0, rdata0_b}, 32'h00);
      check("post_rst_rd4", {31'h0, rvalid1_b}, 32'd0);
      tick();

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
